// File: rtl/design_12_sched.sv
// Round-robin scheduler sharing one design_12 datapath among NREQ requesters, with tagged in-order responses.
// Optional macro D12_SCHED_STATS_EN adds saturating issue_cnt/stall_cnt output ports.
module design_12_sched #(
  parameter int unsigned W     = 12,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     core_start,
  output logic [W-1:0]             core_a,
  output logic [W-1:0]             core_b,
  input  logic [W-1:0]             core_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_y,
`ifdef D12_SCHED_STATS_EN
  output logic                     idle,
  output logic [15:0]              issue_cnt,
  output logic [15:0]              stall_cnt
`else
  output logic                     idle
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   rr_q;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   rr_nxt;
  logic [NREQ-1:0]  gnt;
  logic             accept;
  logic             push;
  logic             pop;
  logic             credit;
  int unsigned      occ;
  int unsigned      idx;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [IDW-1:0]   mem_id_q [DEPTH];
  logic [W-1:0]     mem_y_q  [DEPTH];
  logic             core_start_q;
  logic [W-1:0]     core_a_q;
  logic [W-1:0]     core_b_q;
  logic [IDW-1:0]   core_id_q;
  logic             tag_vld_q [LAT];
  logic [IDW-1:0]   tag_id_q  [LAT];

  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = tag_vld_q[LAT-1];

  // Occupancy counts everything issued but not yet popped, so a full pipe can never overflow the FIFO.
  always_comb begin
    occ    = 32'(cnt_q) + 32'(inflight_q) - 32'(pop);
    credit = (occ < DEPTH);
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    accept  = 1'b0;
    idx     = 0;
    if (state_q == S_RUN && credit) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(rr_q) + k) % NREQ;
        if (!accept && req_valid[idx]) begin
          accept       = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = IDW'(idx);
        end
      end
    end
  end

  assign rr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_id_q    <= '0;
      inflight_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE:  if (enable) state_q <= S_RUN;
        S_RUN:   if (!enable) state_q <= S_DRAIN;
        S_DRAIN: begin
          if (enable)                state_q <= S_RUN;
          else if (inflight_q == '0) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      core_start_q <= accept;
      if (accept) begin
        core_a_q  <= req_a[gnt_idx*W +: W];
        core_b_q  <= req_b[gnt_idx*W +: W];
        core_id_q <= gnt_idx;
        rr_q      <= rr_nxt;
      end
      inflight_q <= inflight_q + CW'(accept) - CW'(push);
    end
  end

  // Tag enters alongside core_start; the last stage lines up with core_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= core_start_q;
      tag_id_q[0]  <= core_id_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_id_q[i] <= '0;
        mem_y_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_id_q[wr_q] <= tag_id_q[LAT-1];
        mem_y_q[wr_q]  <= core_y;
        wr_q           <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign req_ready  = gnt;
  assign core_start = core_start_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign rsp_id     = mem_id_q[rd_q];
  assign rsp_y      = mem_y_q[rd_q];
  assign idle       = (state_q == S_IDLE) && (inflight_q == '0) && (cnt_q == '0);

`ifdef D12_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && issue_cnt != '1) issue_cnt <= issue_cnt + 16'd1;
      if (state_q == S_RUN && (|req_valid) && !accept && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == CW'(DEPTH)));

endmodule

// File: tb/tb_design_12_sched.sv
// Scoreboard bench for design_12_sched: transaction-level arbitration/credit model plus in-order response queue.
module tb_design_12_sched;

  localparam int W     = 12;
  localparam int NREQ  = 4;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              core_start;
  logic [W-1:0]      core_a;
  logic [W-1:0]      core_b;
  logic [W-1:0]      core_y = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_y;
  logic              idle;
`ifdef D12_SCHED_STATS_EN
  logic [15:0]       issue_cnt;
  logic [15:0]       stall_cnt;
`endif

  design_12_sched #(.W(W), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_y(core_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
`ifdef D12_SCHED_STATS_EN
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt),
`endif
    .idle(idle)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: asymmetric function so swapped operands show up, LAT=1 register.
  always @(posedge clk) if (core_start) core_y <= core_a - (core_b << 1);

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int acc_total = 0;
  int last_acc_cyc = 0;
  int last_pop_cyc = 0;
  logic [13:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Issue-side model: enable seen at the previous edge means issuing is allowed;
  // accepted-but-unpopped ops must stay below DEPTH.
  int   rr_m = 0;
  int   outst = 0;
  bit   run_m = 0;
  bit   start_m = 0;
  logic [W-1:0] ea_m, eb_m;

  always @(negedge clk) begin : mon_issue
    logic [NREQ-1:0] eg;
    logic            popm;
    int              gid;
    int              ii;
    logic [W-1:0]    a, b, y;
    logic [1:0]      gv;
    if (!rst_n) begin
      rr_m = 0; outst = 0; run_m = 0; start_m = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_core_start", 32'(core_start), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_y", 32'(rsp_y), 0);
    end else begin
      popm = rsp_valid && rsp_ready;
      eg = '0;
      gid = -1;
      if (run_m && (outst - int'(popm) < DEPTH)) begin
        for (int k = 0; k < NREQ; k++) begin
          ii = (rr_m + k) % NREQ;
          if (gid < 0 && req_valid[ii]) gid = ii;
        end
      end
      if (gid >= 0) eg[gid] = 1'b1;
      chk("grant", 32'(req_ready), 32'(eg));
      chk("core_start", 32'(core_start), 32'(start_m));
      if (start_m) begin
        chk("core_a", 32'(core_a), 32'(ea_m));
        chk("core_b", 32'(core_b), 32'(eb_m));
      end
      if (outst > 0) chk("idle_busy", 32'(idle), 0);
      if (gid >= 0) begin
        a  = req_a[gid*W +: W];
        b  = req_b[gid*W +: W];
        y  = 12'(a - (b << 1));
        gv = 2'(gid);
        exp_q.push_back({gv, y});
        rr_m = (gid + 1) % NREQ;
        start_m = 1; ea_m = a; eb_m = b;
        acc_total++;
        last_acc_cyc = cyc_n;
        outst++;
      end else begin
        start_m = 0;
      end
      if (popm) outst--;
      run_m = enable;
    end
  end

  always @(negedge clk) begin : mon_rsp
    logic [13:0] e;
    bit          hold;
    logic [1:0]  hid;
    logic [W-1:0] hy;
    if (!rst_n) begin
      exp_q.delete();
      hold = 0;
    end else begin
      if (hold) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 1);
        chk("rsp_hold_id", 32'(rsp_id), 32'(hid));
        chk("rsp_hold_y", 32'(rsp_y), 32'(hy));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: actual id=%0d y=%0h required=no response", rsp_id, rsp_y);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e[13:12]));
          chk("rsp_y", 32'(rsp_y), 32'(e[11:0]));
        end
        last_pop_cyc = cyc_n;
      end
      hold = rsp_valid && !rsp_ready;
      hid = rsp_id;
      hy = rsp_y;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 12'($urandom);
      req_b[i*W +: W] = 12'($urandom);
    end
  endtask

  int base;

  initial begin
    rst_n = 1'b0; enable = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    rand_ops();
    step(3);
    rst_n = 1'b1; req_valid = '0;
    step(2);

    // Single op on requester 0.
    enable = 1'b1; rsp_ready = 1'b1;
    rand_ops();
    req_a[0 +: W] = 12'h005; req_b[0 +: W] = 12'h003; req_valid = 4'b0001;
    base = acc_total;
    for (int k = 0; k < 5 && acc_total == base; k++) step(1);
    chk("single_accepted", 32'(acc_total - base), 1);
    req_valid = '0;
    step(6);
    chk("single_latency", 32'(last_pop_cyc - last_acc_cyc), 32'(LAT + 2));

    // Round-robin fairness with all requesters active.
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin rand_ops(); step(1); end
    req_valid = '0;
    step(8);

    // Backpressure: only DEPTH ops fit, then one grant per pop.
    rsp_ready = 1'b0; req_valid = 4'hF;
    base = acc_total;
    for (int k = 0; k < 12; k++) begin rand_ops(); step(1); end
    chk("bp_accept_count", 32'(acc_total - base), 32'(DEPTH));
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin rand_ops(); step(1); end
    req_valid = '0;
    step(8);

    // Drain: stop issuing with ops in flight.
    req_valid = 4'hF;
    step(2);
    enable = 1'b0;
    step(10);
    chk("drain_idle", 32'(idle), 1);
    req_valid = '0;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      enable    = ($urandom_range(0, 9) != 0);
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step(1);
    end

    // Reset with work in flight and in the FIFO.
    enable = 1'b1; rsp_ready = 1'b0; req_valid = 4'hF;
    step(4);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1; enable = 1'b0; req_valid = '0;
    step(3);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("post_rst_idle", 32'(idle), 1);
    enable = 1'b1; rsp_ready = 1'b1; req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin rand_ops(); step(1); end

    // Final drain, bounded.
    enable = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 50 && !(exp_q.size() == 0 && idle); k++) step(1);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_idle", 32'(idle), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
